spi_ram_ctrl: RTL and testbench

//  Single-port RAM with command decoder; sits directly downstream of the SPI slave.

---
 rtl/spi_ram_pkg.sv | 16 +
 rtl/sp_ram_array.sv | 28 ++
 rtl/spi_ram_ctrl.sv | 140 ++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached RAM controller.
// Opcode values carried in rx_data[9:8] and the response FSM state encoding.
// Imported by spi_ram_ctrl and its testbench.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/sp_ram_array.sv
// Single-port synchronous RAM, read-first, read latency 1, contents not reset.
// Ports: clk; i_we write enable; i_addr shared read/write address;
//        i_din write data; o_dout registered read data (mem[i_addr] of previous cycle).
module sp_ram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
    r_dout <= r_mem[i_addr];
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder + RAM behind an SPI slave: one command per rising edge of rx_valid.
// Ports: clk, rst_n (async active-low); i_rx_data {opcode, payload}, i_rx_valid level;
//        o_tx_data/o_tx_valid read response held TX_HOLD cycles; o_busy; o_cmd_err sticky.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int AUTO_INC  = 1,
  parameter int TX_HOLD   = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE+1:0] i_rx_data,
  input  logic                 i_rx_valid,
  output logic [DATA_SIZE-1:0] o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_busy,
  output logic                 o_cmd_err
);

  localparam int HOLD_W = $clog2(TX_HOLD + 1);

  logic                 r_rx_valid_d;
  logic [ADDR_SIZE-1:0] r_wr_ptr;
  logic [ADDR_SIZE-1:0] r_rd_ptr;
  logic                 r_rd_addr_set;
  logic                 r_cmd_err;
  logic                 r_tx_fresh;
  logic [DATA_SIZE-1:0] r_tx_data;
  rsp_state_t           r_state;
  logic [HOLD_W-1:0]    r_hold_cnt;

  logic                 w_accept;
  logic [1:0]           w_op;
  logic [DATA_SIZE-1:0] w_payload;
  logic                 w_wr_data;
  logic                 w_rd_go;
  logic                 w_rd_err;
  logic [ADDR_SIZE-1:0] w_ram_addr;
  logic [DATA_SIZE-1:0] w_ram_dout;
  rsp_state_t           w_state_nxt;
  logic [HOLD_W-1:0]    w_hold_nxt;

  // rx_valid is a level held for the whole SPI frame; act only on its rising edge.
  assign w_accept  = i_rx_valid & ~r_rx_valid_d;
  assign w_op      = i_rx_data[DATA_SIZE+1:DATA_SIZE];
  assign w_payload = i_rx_data[DATA_SIZE-1:0];
  assign w_wr_data = w_accept && (w_op == OP_WR_DATA);
  assign w_rd_go   = w_accept && (w_op == OP_RD_DATA) && r_rd_addr_set;
  assign w_rd_err  = w_accept && (w_op == OP_RD_DATA) && !r_rd_addr_set;

  // Single port: the write pointer owns the port only in a WR_DATA accept cycle.
  assign w_ram_addr = w_wr_data ? r_wr_ptr : r_rd_ptr;

  sp_ram_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_SIZE),
    .DW    (DATA_SIZE)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_wr_data),
    .i_addr (w_ram_addr),
    .i_din  (w_payload),
    .o_dout (w_ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_valid_d  <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rd_addr_set <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_rx_valid_d <= i_rx_valid;
      if (w_accept) begin
        case (w_op)
          OP_WR_ADDR: r_wr_ptr <= w_payload[ADDR_SIZE-1:0];
          OP_WR_DATA: if (AUTO_INC != 0) r_wr_ptr <= r_wr_ptr + ADDR_SIZE'(1);
          OP_RD_ADDR: begin
            r_rd_ptr      <= w_payload[ADDR_SIZE-1:0];
            r_rd_addr_set <= 1'b1;
          end
          default: begin
            if (r_rd_addr_set && (AUTO_INC != 0)) r_rd_ptr <= r_rd_ptr + ADDR_SIZE'(1);
          end
        endcase
      end
      if (w_rd_err) r_cmd_err <= 1'b1;
    end
  end

  // The RAM output register already holds the read word one edge after accept,
  // so it is presented directly for that cycle and captured locally afterwards;
  // this keeps tx_data stable while later commands reuse the RAM port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_fresh <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_fresh <= w_rd_go;
      if (r_tx_fresh) r_tx_data <= w_ram_dout;
    end
  end

  assign o_tx_data = r_tx_fresh ? w_ram_dout : r_tx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // A new read always (re)starts the hold window, including mid-HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    if (w_rd_go) begin
      w_state_nxt = ST_HOLD;
      w_hold_nxt  = HOLD_W'(TX_HOLD - 1);
    end else if (r_state == ST_HOLD) begin
      if (r_hold_cnt == '0) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_hold_nxt = r_hold_cnt - HOLD_W'(1);
      end
    end
  end

  assign o_tx_valid = (r_state == ST_HOLD);
  assign o_busy     = (r_state == ST_HOLD);
  assign o_cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed self-checking bench for spi_ram_ctrl.
// Commands are driven on the falling edge; outputs are sampled on the falling edge.
// Each scenario task checks its own expectations inline.
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  localparam int TX_HOLD = 9;

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       cmd_err;

  int total = 0;
  int bad   = 0;

  spi_ram_ctrl #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8),
    .DATA_SIZE (8),
    .AUTO_INC  (1),
    .TX_HOLD   (TX_HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_busy     (busy),
    .o_cmd_err  (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One rx_valid pulse of `hold` cycles, followed by one idle cycle.
  task automatic send(input logic [1:0] op, input logic [7:0] pl, input int hold);
    @(negedge clk);
    rx_data  = {op, pl};
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  // Issue RD_DATA and expect a TX_HOLD-cycle response carrying `exp`.
  task automatic rd_check(input logic [7:0] exp, input string name);
    int n;
    @(negedge clk);
    rx_data  = {OP_RD_DATA, 8'h00};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    total++;
    if (tx_valid !== 1'b1 || tx_data !== exp) begin
      bad++;
      $display("FAIL %s first: tx_valid=%b tx_data=%h want 1/%h", name, tx_valid, tx_data, exp);
    end
    n = 0;
    while (tx_valid === 1'b1 && n < 30) begin
      total++;
      if (tx_data !== exp || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s hold cyc %0d: tx_data=%h busy=%b want %h/1", name, n, tx_data, busy, exp);
      end
      n++;
      @(negedge clk);
    end
    total++;
    if (n != TX_HOLD) begin
      bad++;
      $display("FAIL %s valid_len: got %0d want %0d", name, n, TX_HOLD);
    end
  endtask

  // RD_DATA without a prior RD_ADDR: error flag, no response.
  task automatic rd_err_check(input string name);
    int hi;
    @(negedge clk);
    rx_data  = {OP_RD_DATA, 8'h00};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    hi = 0;
    repeat (12) begin
      if (tx_valid !== 1'b0) hi++;
      @(negedge clk);
    end
    total++;
    if (cmd_err !== 1'b1 || hi != 0) begin
      bad++;
      $display("FAIL %s: cmd_err=%b valid_cycles=%0d want 1/0", name, cmd_err, hi);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0 || cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: tx_data=%h tx_valid=%b busy=%b cmd_err=%b want 00/0/0/0",
               tx_data, tx_valid, busy, cmd_err);
    end
  endtask

  task automatic test_write_read();
    send(OP_WR_ADDR, 8'h10, 1);
    send(OP_WR_DATA, 8'hA5, 1);
    send(OP_RD_ADDR, 8'h10, 1);
    rd_check(8'hA5, "write_read");
    total++;
    if (tx_data !== 8'hA5 || busy !== 1'b0) begin
      bad++;
      $display("FAIL write_read after_hold: tx_data=%h busy=%b want a5/0", tx_data, busy);
    end
  endtask

  task automatic test_level_held();
    send(OP_WR_ADDR, 8'h05, 1);
    send(OP_WR_DATA, 8'h00, 1);
    send(OP_WR_DATA, 8'h00, 1);
    send(OP_WR_DATA, 8'h00, 1);
    send(OP_WR_ADDR, 8'h05, 1);
    send(OP_WR_DATA, 8'h3C, 20);
    total++;
    if (dut.r_wr_ptr !== 8'h06) begin
      bad++;
      $display("FAIL level_held wr_ptr: got %h want 06", dut.r_wr_ptr);
    end
    send(OP_WR_DATA, 8'h77, 1);
    send(OP_RD_ADDR, 8'h05, 1);
    rd_check(8'h3C, "level_held mem05");
    rd_check(8'h77, "level_held mem06");
    rd_check(8'h00, "level_held mem07");
  endtask

  task automatic test_burst_wrap();
    send(OP_WR_ADDR, 8'hFF, 1);
    send(OP_WR_DATA, 8'h11, 1);
    send(OP_WR_DATA, 8'h22, 1);
    total++;
    if (dut.r_wr_ptr !== 8'h01) begin
      bad++;
      $display("FAIL burst wr_ptr_wrap: got %h want 01", dut.r_wr_ptr);
    end
    send(OP_RD_ADDR, 8'hFF, 1);
    rd_check(8'h11, "burst memff");
    rd_check(8'h22, "burst mem00");
  endtask

  task automatic test_read_err();
    do_reset();
    rd_err_check("read_err after_reset");
    send(OP_RD_ADDR, 8'h10, 1);
    rd_check(8'hA5, "read_err recover");
    total++;
    if (cmd_err !== 1'b1) begin
      bad++;
      $display("FAIL read_err sticky: cmd_err=%b want 1", cmd_err);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic gap;
    send(OP_RD_ADDR, 8'hFF, 1);
    @(negedge clk);
    rx_data  = {OP_RD_DATA, 8'h00};
    rx_valid = 1'b1;
    @(negedge clk);                 // HOLD cycle 1
    rx_valid = 1'b0;
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
      bad++;
      $display("FAIL restart first: tx_valid=%b tx_data=%h want 1/11", tx_valid, tx_data);
    end
    n = 1;
    gap = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n++;
      if (tx_valid !== 1'b1) gap = 1'b1;
    end
    rx_valid = 1'b1;                // accepted on the 5th HOLD edge
    @(negedge clk);
    rx_valid = 1'b0;
    total++;
    if (tx_data !== 8'h22) begin
      bad++;
      $display("FAIL restart second_word: tx_data=%h want 22", tx_data);
    end
    while (tx_valid === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (gap || n != 4 + TX_HOLD) begin
      bad++;
      $display("FAIL restart valid_len: got %0d gap=%b want %0d gap=0", n, gap, 4 + TX_HOLD);
    end
  endtask

  task automatic test_reset_mid_hold();
    send(OP_RD_ADDR, 8'h10, 1);
    @(negedge clk);
    rx_data  = {OP_RD_DATA, 8'h00};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);                 // third HOLD cycle
    total++;
    if (tx_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_hold pre: tx_valid=%b want 1", tx_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL mid_hold async: tx_valid=%b busy=%b tx_data=%h cmd_err=%b want 0/0/00/0",
               tx_valid, busy, tx_data, cmd_err);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_err_check("mid_hold rd_addr_cleared");
  endtask

  initial begin
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    test_reset();
    test_write_read();
    test_level_held();
    test_burst_wrap();
    test_read_err();
    test_back_to_back();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
